mc_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the 16/32-bit MIPS datapath. Sequences fetch, decode, execute, memory and write-back for the supported subset, and drives the 16-bit immediate OR-fill bank's control input (`ext_fill`) to sign- or zero-extend immediates. It sits beside the datapath: it reads opcode, funct, immediate MSB, ALU zero and memory ready, and emits every datapath enable and select.

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/mc_ctrl_decode.sv | 75 +++++++
 rtl/mc_ctrl_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_R_WB     = 4'd8,
      S_EXEC_I   = 4'd9,
      S_I_WB     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_SLT   = 3'd4;
   localparam logic [2:0] ALU_FUNCT = 3'd7;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] CLS_ILLEGAL = 3'd0;
   localparam logic [2:0] CLS_MEM     = 3'd1;
   localparam logic [2:0] CLS_R       = 3'd2;
   localparam logic [2:0] CLS_I       = 3'd3;
   localparam logic [2:0] CLS_BRANCH  = 3'd4;
   localparam logic [2:0] CLS_JUMP    = 3'd5;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to class, extension
// mode, legality, store flag and the ALU operation used by I-type ALU ops.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] instr_class,
   output logic       sign_ext,
   output logic       legal,
   output logic       is_store,
   output logic [2:0] i_alu_op
);

   always_comb begin
      instr_class = CLS_ILLEGAL;
      sign_ext    = 1'b0;
      legal       = 1'b0;
      is_store    = 1'b0;
      i_alu_op    = ALU_ADD;
      case (opcode)
         OP_R: begin
            if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
               instr_class = CLS_R;
               legal       = 1'b1;
            end
         end
         OP_LW: begin
            instr_class = CLS_MEM;
            sign_ext    = 1'b1;
            legal       = 1'b1;
         end
         OP_SW: begin
            instr_class = CLS_MEM;
            sign_ext    = 1'b1;
            legal       = 1'b1;
            is_store    = 1'b1;
         end
         OP_ADDI: begin
            instr_class = CLS_I;
            sign_ext    = 1'b1;
            legal       = 1'b1;
            i_alu_op    = ALU_ADD;
         end
         OP_SLTI: begin
            instr_class = CLS_I;
            sign_ext    = 1'b1;
            legal       = 1'b1;
            i_alu_op    = ALU_SLT;
         end
         // Logical immediates are zero-extended
         OP_ANDI: begin
            instr_class = CLS_I;
            legal       = 1'b1;
            i_alu_op    = ALU_AND;
         end
         OP_ORI: begin
            instr_class = CLS_I;
            legal       = 1'b1;
            i_alu_op    = ALU_OR;
         end
         OP_BEQ: begin
            instr_class = CLS_BRANCH;
            sign_ext    = 1'b1;
            legal       = 1'b1;
         end
         OP_J: begin
            instr_class = CLS_JUMP;
            legal       = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM driving every datapath enable/select.
// Define MC_CTRL_PERF_EN to add the instr_count/stall_count counters.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter bit RESET_PC_HOLD = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        imm_msb,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic        ext_fill,
   output logic        illegal
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] instr_count,
   output logic [31:0] stall_count
`endif
);

   localparam state_t RST_STATE = RESET_PC_HOLD ? S_IDLE : S_FETCH;

   state_t     state, state_next;
   logic [2:0] instr_class;
   logic       sign_ext, legal, is_store;
   logic [2:0] i_alu_op;

   // The zero flag is gated with pc_write_cond in the datapath, not here
   logic unused_alu_zero;
   assign unused_alu_zero = alu_zero;

   mc_ctrl_decode u_decode (
      .opcode      (opcode),
      .funct       (funct),
      .instr_class (instr_class),
      .sign_ext    (sign_ext),
      .legal       (legal),
      .is_store    (is_store),
      .i_alu_op    (i_alu_op)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RST_STATE;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'd0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = ALU_ADD;
      illegal       = 1'b0;
      ext_fill      = 1'b0;

      case (state)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'd3;
            illegal   = ~legal;
            case (instr_class)
               CLS_MEM:    state_next = S_MEM_ADDR;
               CLS_R:      state_next = S_EXEC_R;
               CLS_I:      state_next = S_EXEC_I;
               CLS_BRANCH: state_next = S_BRANCH;
               CLS_JUMP:   state_next = S_JUMP;
               default:    state_next = S_FETCH;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            state_next = is_store ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) state_next = S_MEM_WB;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) state_next = S_FETCH;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_next = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_FUNCT;
            state_next = S_R_WB;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            state_next = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            alu_op     = i_alu_op;
            state_next = S_I_WB;
         end
         S_I_WB: begin
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = 2'd1;
            state_next    = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            state_next = S_FETCH;
         end
         default: state_next = RST_STATE;
      endcase

      if (state inside {S_DECODE, S_MEM_ADDR, S_EXEC_I, S_BRANCH})
         ext_fill = sign_ext & imm_msb;

      // Held reset silences every output, including a FETCH reset state
      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         pc_src        = 2'd0;
         ir_write      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         iord          = 1'b0;
         reg_write     = 1'b0;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'd0;
         alu_op        = ALU_ADD;
         illegal       = 1'b0;
         ext_fill      = 1'b0;
      end
   end

`ifdef MC_CTRL_PERF_EN
   logic completing, stalling;

   assign completing = (state_next == S_FETCH) &&
                       (state inside {S_MEM_WR, S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP});
   assign stalling   = !mem_ready && (state inside {S_FETCH, S_MEM_RD, S_MEM_WR});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_count <= '0;
         stall_count <= '0;
      end else begin
         if (completing) instr_count <= instr_count + 32'd1;
         if (stalling)   stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-instruction cycle scripts feed an
// expected-output queue that a negedge monitor drains and compares.
module tb_mc_ctrl_fsm;

   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
   localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3, A_SLT = 3'd4, A_FUNCT = 3'd7;

   typedef struct packed {
      logic       pcw, pcwc;
      logic [1:0] pcs;
      logic       irw, mr, mw, iord, rw, rdst, m2r, asa;
      logic [1:0] asb;
      logic [2:0] aop;
      logic       ef, ill;
   } ov_t;

   typedef struct {
      string nm;
      ov_t   v;
   } exp_t;

   logic        clk, reset;
   logic [5:0]  opcode, funct;
   logic        imm_msb, alu_zero, mem_ready;
   logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
   logic        reg_write, reg_dst, mem_to_reg, alu_src_a, ext_fill, illegal;
   logic [1:0]  pc_src, alu_src_b;
   logic [2:0]  alu_op;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] instr_count, stall_count;
`endif

   mc_ctrl_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .imm_msb(imm_msb), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
      .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .ext_fill(ext_fill), .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
      , .instr_count(instr_count), .stall_count(stall_count)
`endif
   );

   ov_t dut_v;
   assign dut_v = {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write, iord,
                   reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_fill, illegal};

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   int unsigned instr_m = 0;
   int unsigned stall_m = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t ent;
         ent = exp_q.pop_front();
         chk(ent.nm, 32'(dut_v), 32'(ent.v));
      end
   end

   task automatic drive_cycle(input logic mr, input ov_t e, input string nm);
      mem_ready = mr;
      exp_q.push_back('{nm, e});
      @(posedge clk);
      #1;
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic ov_t fetch_v(input logic done);
      ov_t e;
      e = '0;
      e.mr = 1'b1; e.asb = 2'd1; e.aop = A_ADD;
      e.irw = done; e.pcw = done;
      return e;
   endfunction

   // Cycle-by-cycle expectation of one instruction, built from the ISA rules
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic msb,
                            input logic z, input int wf, input int wm, input string tag);
      logic sx, lg, ef;
      logic [2:0] iop;
      ov_t e;
      sx = op inside {OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ};
      lg = (op == OP_R && (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})) ||
           (op inside {OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW});
      ef = sx & msb;
      opcode = op; funct = fn; imm_msb = msb; alu_zero = z;

      for (int i = 0; i < wf; i++) begin
         drive_cycle(1'b0, fetch_v(1'b0), {tag, ":fetch_wait"});
         stall_m++;
      end
      drive_cycle(1'b1, fetch_v(1'b1), {tag, ":fetch"});

      e = '0; e.asb = 2'd3; e.aop = A_ADD; e.ef = ef; e.ill = !lg;
      drive_cycle(rnd_bit(), e, {tag, ":decode"});
      if (!lg) return;

      if (op == OP_LW || op == OP_SW) begin
         e = '0; e.asa = 1'b1; e.asb = 2'd2; e.aop = A_ADD; e.ef = ef;
         drive_cycle(rnd_bit(), e, {tag, ":mem_addr"});
         e = '0; e.iord = 1'b1;
         if (op == OP_LW) e.mr = 1'b1; else e.mw = 1'b1;
         for (int i = 0; i < wm; i++) begin
            drive_cycle(1'b0, e, {tag, ":mem_wait"});
            stall_m++;
         end
         drive_cycle(1'b1, e, {tag, ":mem_done"});
         if (op == OP_LW) begin
            e = '0; e.rw = 1'b1; e.m2r = 1'b1;
            drive_cycle(rnd_bit(), e, {tag, ":mem_wb"});
         end
      end else if (op == OP_R) begin
         e = '0; e.asa = 1'b1; e.asb = 2'd0; e.aop = A_FUNCT;
         drive_cycle(rnd_bit(), e, {tag, ":exec_r"});
         e = '0; e.rw = 1'b1; e.rdst = 1'b1;
         drive_cycle(rnd_bit(), e, {tag, ":r_wb"});
      end else if (op == OP_BEQ) begin
         e = '0; e.asa = 1'b1; e.aop = A_SUB; e.pcwc = 1'b1; e.pcs = 2'd1; e.ef = ef;
         drive_cycle(rnd_bit(), e, {tag, ":branch"});
      end else if (op == OP_J) begin
         e = '0; e.pcw = 1'b1; e.pcs = 2'd2;
         drive_cycle(rnd_bit(), e, {tag, ":jump"});
      end else begin
         case (op)
            OP_SLTI: iop = A_SLT;
            OP_ANDI: iop = A_AND;
            OP_ORI:  iop = A_OR;
            default: iop = A_ADD;
         endcase
         e = '0; e.asa = 1'b1; e.asb = 2'd2; e.aop = iop; e.ef = ef;
         drive_cycle(rnd_bit(), e, {tag, ":exec_i"});
         e = '0; e.rw = 1'b1;
         drive_cycle(rnd_bit(), e, {tag, ":i_wb"});
      end
      instr_m++;
   endtask

   task automatic check_counters(input string nm);
`ifdef MC_CTRL_PERF_EN
      chk({nm, ":instr_count"}, instr_count, instr_m);
      chk({nm, ":stall_count"}, stall_count, stall_m);
`else
      nm = nm;
`endif
   endtask

   initial begin
      ov_t e;
      int  k;
      logic [5:0] rop, rfn;
      reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0; imm_msb = 1'b0; alu_zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'(dut_v), 32'd0);
      check_counters("reset");
      reset = 1'b0;
      drive_cycle(rnd_bit(), '0, "idle_after_reset");

      run_instr(OP_ADDI, 6'h3C, 1'b1, 1'b0, 0, 0, "addi_neg");
      run_instr(OP_ORI,  6'h00, 1'b1, 1'b0, 0, 0, "ori_8000");
`ifdef MC_CTRL_PERF_EN
      k = int'(stall_count);
`endif
      run_instr(OP_LW, 6'h00, 1'b0, 1'b0, 2, 3, "lw_waits");
`ifdef MC_CTRL_PERF_EN
      chk("lw_stall_delta", stall_count - 32'(k), 32'd5);
`endif
      run_instr(OP_BEQ, 6'h00, 1'b1, 1'b1, 0, 0, "beq_taken");
      run_instr(OP_BEQ, 6'h00, 1'b0, 1'b0, 0, 0, "beq_not");
      check_counters("directed_a");
      run_instr(6'h3F, 6'h00, 1'b1, 1'b0, 0, 0, "illegal_3f");
      check_counters("after_illegal");
      run_instr(OP_R, FN_SLT, 1'b0, 1'b0, 1, 0, "r_slt");
      run_instr(OP_R, 6'h21, 1'b0, 1'b0, 0, 0, "r_bad_funct");
      run_instr(OP_SW, 6'h00, 1'b1, 1'b0, 0, 2, "sw_waits");
      run_instr(OP_J, 6'h00, 1'b1, 1'b0, 0, 0, "jump");
      run_instr(OP_ANDI, 6'h00, 1'b1, 1'b0, 0, 0, "andi");
      run_instr(OP_SLTI, 6'h00, 1'b1, 1'b0, 0, 0, "slti");
      check_counters("directed_b");

      // Reset in the middle of a stalled load
      opcode = OP_LW; imm_msb = 1'b0;
      drive_cycle(1'b1, fetch_v(1'b1), "rst_lw:fetch");
      e = '0; e.asb = 2'd3; e.aop = A_ADD;
      drive_cycle(1'b0, e, "rst_lw:decode");
      e = '0; e.asa = 1'b1; e.asb = 2'd2; e.aop = A_ADD;
      drive_cycle(1'b0, e, "rst_lw:mem_addr");
      e = '0; e.mr = 1'b1; e.iord = 1'b1;
      drive_cycle(1'b0, e, "rst_lw:mem_wait");
      reset = 1'b1;
      #1;
      chk("reset_async_zero", 32'(dut_v), 32'd0);
      @(posedge clk);
      #1;
      chk("reset_held_zero", 32'(dut_v), 32'd0);
      instr_m = 0; stall_m = 0;
      check_counters("reset_mid");
      reset = 1'b0;
      drive_cycle(1'b0, '0, "idle_after_midreset");

      for (int n = 0; n < 80; n++) begin
         k = int'($urandom_range(0, 15));
         rfn = 6'($urandom);
         case (k)
            0:  begin rop = OP_R; rfn = FN_ADD; end
            1:  begin rop = OP_R; rfn = FN_SUB; end
            2:  begin rop = OP_R; rfn = FN_AND; end
            3:  begin rop = OP_R; rfn = FN_OR;  end
            4:  begin rop = OP_R; rfn = FN_SLT; end
            5:  rop = OP_ADDI;
            6:  rop = OP_SLTI;
            7:  rop = OP_ANDI;
            8:  rop = OP_ORI;
            9:  rop = OP_LW;
            10: rop = OP_SW;
            11: rop = OP_BEQ;
            12: rop = OP_J;
            13: rop = OP_R;
            default: rop = 6'($urandom);
         endcase
         run_instr(rop, rfn, rnd_bit(), rnd_bit(), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), "rand");
      end
      check_counters("final");
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
